simple16_trace_buf: RTL and testbench

- Downstream consumer of the simple16_cpu observation ports.
- Captures register-file write commits into a FIFO, each stamped with the PC and a free-running cycle timestamp.
- Supports arm, optional PC trigger and stop controls; the buffer drains through a valid/ready read port.
- Used by benches and on-chip debug to reconstruct the executed write stream without per-cycle $display polling.

---
 rtl/simple16_trace_pkg.sv | 20 ++
 rtl/simple16_trace_fifo.sv | 57 +++++
 rtl/simple16_trace_buf.sv | 118 +++++++++++
 tb/tb_simple16_trace_buf.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple16_trace_pkg.sv
// Shared constants for the simple16 write-commit trace buffer:
// state encodings and trace entry field widths.
package simple16_trace_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int PC_W = 16;
    localparam int RA_W = 3;
    localparam int RD_W = 16;
    localparam int ENTRY_FIXED_W = PC_W + RA_W + RD_W;

    // An entry is {ts, pc, waddr, wdata}; only the timestamp width varies.
    function automatic int entry_width(input int ts_w);
        return ts_w + ENTRY_FIXED_W;
    endfunction

endpackage

// File: rtl/simple16_trace_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always visible on head_data.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module simple16_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 51
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full      = (cnt == FULL_CNT);
    assign empty     = (cnt == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign count     = cnt;
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/simple16_trace_buf.sv
// Captures simple16_cpu register-file write commits, stamped with PC and a
// free-running timestamp, into a FIFO drained through a valid/ready port.
module simple16_trace_buf
    import simple16_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PC_W-1:0]         obs_pc,
    input  logic                    obs_reg_we,
    input  logic [RA_W-1:0]         obs_reg_waddr,
    input  logic [RD_W-1:0]         obs_reg_wdata,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    trig_en,
    input  logic [PC_W-1:0]         trig_pc,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [TS_W-1:0]         rd_ts,
    output logic [PC_W-1:0]         rd_pc,
    output logic [RA_W-1:0]         rd_waddr,
    output logic [RD_W-1:0]         rd_wdata,
    output logic [1:0]              state,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int ENTRY_W = entry_width(TS_W);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [TS_W-1:0]    ts;
    logic               overflow_q;
    logic               trig_hit;
    logic               active;
    logic               cap;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign trig_hit = trig_en ? (obs_pc == trig_pc) : 1'b1;

    always_comb begin
        active = 1'b0;
        case (state_q)
            ST_ARMED:   active = trig_hit;
            ST_CAPTURE: active = 1'b1;
            default:    active = 1'b0;
        endcase
    end

    // arm wins over everything else in its cycle, so it suppresses capture and pop.
    assign cap        = obs_reg_we && active && !arm;
    assign rd_valid   = !empty;
    assign pop        = rd_valid && rd_ready && !arm;
    assign drop       = cap && full && !pop;
    assign push_entry = {ts, obs_pc, obs_reg_waddr, obs_reg_wdata};

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (stop || drop)  state_d = ST_DONE;
                    else if (trig_hit) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (stop || drop) state_d = ST_DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ts         <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ts      <= ts + 1'b1;
            if (arm)       overflow_q <= 1'b0;
            else if (drop) overflow_q <= 1'b1;
        end
    end

    simple16_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (arm),
        .push      (cap),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign rd_ts    = head_entry[ENTRY_W-1 -: TS_W];
    assign rd_pc    = head_entry[RA_W+RD_W +: PC_W];
    assign rd_waddr = head_entry[RD_W +: RA_W];
    assign rd_wdata = head_entry[RD_W-1:0];
    assign state    = state_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_simple16_trace_buf.sv
// Self-checking bench for simple16_trace_buf: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_simple16_trace_buf;

    localparam int DEPTH = 16;
    localparam int TS_W  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] obs_pc = '0;
    logic        obs_reg_we = 1'b0;
    logic [2:0]  obs_reg_waddr = '0;
    logic [15:0] obs_reg_wdata = '0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        trig_en = 1'b0;
    logic [15:0] trig_pc = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [15:0] rd_ts;
    logic [15:0] rd_pc;
    logic [2:0]  rd_waddr;
    logic [15:0] rd_wdata;
    logic [1:0]  state;
    logic [4:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    simple16_trace_buf #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .obs_pc        (obs_pc),
        .obs_reg_we    (obs_reg_we),
        .obs_reg_waddr (obs_reg_waddr),
        .obs_reg_wdata (obs_reg_wdata),
        .arm           (arm),
        .stop          (stop),
        .trig_en       (trig_en),
        .trig_pc       (trig_pc),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_ts         (rd_ts),
        .rd_pc         (rd_pc),
        .rd_waddr      (rd_waddr),
        .rd_wdata      (rd_wdata),
        .state         (state),
        .count         (count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of captured entries plus the capture mode.
    typedef struct {
        logic [15:0] ts;
        logic [15:0] pc;
        logic [2:0]  wa;
        logic [15:0] wd;
    } ent_t;

    ent_t        m_q[$];
    int          m_state = 0;
    bit          m_ovf = 1'b0;
    logic [15:0] m_ts = '0;

    task automatic model_step();
        bit pop_now;
        bit act;
        bit lost;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_state = 0;
            m_ovf = 1'b0;
            m_ts = '0;
            return;
        end
        pop_now = rd_ready && (m_q.size() != 0);
        if (arm) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_state = 1;
            m_ts++;
            return;
        end
        act = (m_state == 2) || (m_state == 1 && (!trig_en || obs_pc == trig_pc));
        if (pop_now) void'(m_q.pop_front());
        lost = 1'b0;
        if (act && obs_reg_we) begin
            if (m_q.size() < DEPTH) begin
                e.ts = m_ts; e.pc = obs_pc; e.wa = obs_reg_waddr; e.wd = obs_reg_wdata;
                m_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
                lost = 1'b1;
            end
        end
        if (m_state == 1 || m_state == 2) begin
            if (stop || lost) m_state = 3;
            else if (act)     m_state = 2;
        end
        m_ts++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; arm = 1'b0; stop = 1'b0; obs_reg_we = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        clear_inputs();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d expected 0", state); end
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", rd_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b expected 0", overflow); end
        for (int i = 0; i < 5; i++) begin
            obs_reg_we = 1'b1; obs_reg_waddr = 3'(i); obs_reg_wdata = 16'($urandom); obs_pc = 16'(i);
            step();
        end
        obs_reg_we = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL idle_state got %0d expected 0", state); end
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL idle_count got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid got %b expected 0", rd_valid); end
    endtask

    task automatic test_capture_order();
        logic [15:0] base_ts;
        clear_inputs();
        trig_en = 1'b0; arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            obs_reg_we = 1'b1; obs_reg_waddr = 3'(i); obs_reg_wdata = 16'(16'h1111 * i); obs_pc = 16'(16'h0100 + i);
            step();
        end
        obs_reg_we = 1'b0;
        checks++; if (count !== 5'd3) begin errors++; $display("[TB] FAIL order_count got %0d expected 3", count); end
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL order_state got %0d expected 2", state); end
        base_ts = m_q[0].ts;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL order_valid%0d got %b expected 1", i, rd_valid); end
            checks++; if (rd_waddr !== 3'(i + 1)) begin errors++; $display("[TB] FAIL order_waddr%0d got %0d expected %0d", i, rd_waddr, i + 1); end
            checks++; if (rd_wdata !== 16'(16'h1111 * (i + 1))) begin errors++; $display("[TB] FAIL order_wdata%0d got %h expected %h", i, rd_wdata, 16'(16'h1111 * (i + 1))); end
            checks++; if (rd_ts !== 16'(base_ts + 16'(i))) begin errors++; $display("[TB] FAIL order_ts%0d got %h expected %h", i, rd_ts, 16'(base_ts + 16'(i))); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL order_drained got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL order_empty got %b expected 0", rd_valid); end
    endtask

    task automatic test_trigger();
        logic [15:0] pcs [3];
        pcs[0] = 16'h000C; pcs[1] = 16'h0010; pcs[2] = 16'h0012;
        clear_inputs();
        trig_en = 1'b1; trig_pc = 16'h0010; arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs_reg_we = 1'b1; obs_pc = pcs[i]; obs_reg_waddr = 3'(i + 4); obs_reg_wdata = 16'($urandom);
            step();
        end
        obs_reg_we = 1'b0;
        checks++; if (count !== 5'd2) begin errors++; $display("[TB] FAIL trig_count got %0d expected 2", count); end
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL trig_state got %0d expected 2", state); end
        checks++; if (rd_pc !== 16'h0010) begin errors++; $display("[TB] FAIL trig_head_pc got %h expected 0010", rd_pc); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        checks++; if (rd_pc !== 16'h0012) begin errors++; $display("[TB] FAIL trig_second_pc got %h expected 0012", rd_pc); end
        trig_en = 1'b0;
    endtask

    task automatic test_overflow();
        clear_inputs();
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 18; i++) begin
            obs_reg_we = 1'b1; obs_pc = 16'h0200; obs_reg_waddr = 3'(i); obs_reg_wdata = 16'(i);
            step();
        end
        obs_reg_we = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count got %0d expected 16", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b expected 1", overflow); end
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL ovf_state got %0d expected 3", state); end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_wdata !== 16'(i)) begin errors++; $display("[TB] FAIL ovf_entry%0d got %h expected %h", i, rd_wdata, 16'(i)); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained got %b expected 0", rd_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b expected 1", overflow); end
    endtask

    task automatic test_full_passthrough();
        clear_inputs();
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 16; i++) begin
            obs_reg_we = 1'b1; obs_pc = 16'h0300; obs_reg_waddr = 3'(i); obs_reg_wdata = 16'(i);
            step();
        end
        obs_reg_wdata = 16'hBEEF; rd_ready = 1'b1;
        step();
        obs_reg_we = 1'b0; rd_ready = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL pass_count got %0d expected 16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pass_overflow got %b expected 0", overflow); end
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL pass_state got %0d expected 2", state); end
        checks++; if (rd_wdata !== 16'h0001) begin errors++; $display("[TB] FAIL pass_head got %h expected 0001", rd_wdata); end
        rd_ready = 1'b1;
        for (int i = 0; i < 15; i++) step();
        rd_ready = 1'b0;
        checks++; if (rd_wdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL pass_tail got %h expected beef", rd_wdata); end
        checks++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL pass_tail_count got %0d expected 1", count); end
    endtask

    task automatic test_arm_and_reset_mid();
        clear_inputs();
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            obs_reg_we = 1'b1; obs_reg_wdata = 16'($urandom); step();
        end
        checks++; if (count !== 5'd5) begin errors++; $display("[TB] FAIL rearm_pre_count got %0d expected 5", count); end
        arm = 1'b1; stop = 1'b1; rd_ready = 1'b1;
        step();
        clear_inputs();
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL rearm_count got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rearm_valid got %b expected 0", rd_valid); end
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL rearm_state got %0d expected 1", state); end
        for (int i = 0; i < 5; i++) begin
            obs_reg_we = 1'b1; obs_reg_wdata = 16'($urandom); step();
        end
        rst = 1'b1;
        step();
        clear_inputs();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rst_state got %0d expected 0", state); end
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL rst_count got %0d expected 0", count); end
        arm = 1'b1;
        step();
        arm = 1'b0; obs_reg_we = 1'b1; obs_reg_wdata = 16'h5A5A;
        step();
        obs_reg_we = 1'b0;
        checks++; if (rd_ts !== 16'd1) begin errors++; $display("[TB] FAIL rst_ts got %0d expected 1", rd_ts); end
    endtask

    task automatic test_random();
        logic [15:0] pc_pool [4];
        pc_pool[0] = 16'h000C; pc_pool[1] = 16'h0010; pc_pool[2] = 16'h0012; pc_pool[3] = 16'h0040;
        trig_pc = 16'h0010;
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst           = ($urandom_range(0, 199) == 0);
            arm           = ($urandom_range(0, 39) == 0);
            stop          = ($urandom_range(0, 49) == 0);
            if (arm) trig_en = 1'($urandom_range(0, 1));
            obs_reg_we    = 1'($urandom_range(0, 3) != 0);
            obs_pc        = pc_pool[$urandom_range(0, 3)];
            obs_reg_waddr = 3'($urandom);
            obs_reg_wdata = 16'($urandom);
            rd_ready      = (cyc < 400) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0);
            step();
            checks++; if (state !== 2'(m_state)) begin errors++; $display("[TB] FAIL rand_state cyc %0d got %0d expected %0d", cyc, state, m_state); end
            checks++; if (count !== 5'(m_q.size())) begin errors++; $display("[TB] FAIL rand_count cyc %0d got %0d expected %0d", cyc, count, m_q.size()); end
            checks++; if (rd_valid !== (m_q.size() != 0)) begin errors++; $display("[TB] FAIL rand_valid cyc %0d got %b expected %b", cyc, rd_valid, m_q.size() != 0); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("[TB] FAIL rand_overflow cyc %0d got %b expected %b", cyc, overflow, m_ovf); end
            if (m_q.size() != 0) begin
                checks++;
                if ({rd_ts, rd_pc, rd_waddr, rd_wdata} !== {m_q[0].ts, m_q[0].pc, m_q[0].wa, m_q[0].wd}) begin
                    errors++;
                    $display("[TB] FAIL rand_head cyc %0d got %h/%h/%0d/%h expected %h/%h/%0d/%h", cyc,
                             rd_ts, rd_pc, rd_waddr, rd_wdata, m_q[0].ts, m_q[0].pc, m_q[0].wa, m_q[0].wd);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_capture_order();
        test_trigger();
        test_overflow();
        test_full_passthrough();
        test_arm_and_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
